// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port among N_REQ producers.
// One producer owns the port for up to BURST accepted beats; ownership rotates
// with the previous owner at lowest priority, and handover costs no bubble cycle.
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_REQ = 4,
  parameter int unsigned BURST = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       fifo_wr_rq,
  output logic [WIDTH-1:0]           fifo_wdata,
  input  logic                       fifo_full,
  output logic [CNT_W-1:0]           beat_total
);

  localparam int unsigned OW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(BURST + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StOwn  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_owner_q, last_owner_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] beat_total_q, beat_total_d;

  logic             owner_req;
  logic             beat;
  logic             burst_end;
  logic             handover;
  logic             any_req;
  logic [OW-1:0]    arb_base;
  logic [OW-1:0]    cand;
  logic [OW-1:0]    win_idx;
  logic             win_found;
  logic [N_REQ-1:0] win_onehot;

  assign owner_req = req[owner_q];
  // No beat is allowed while reset is held, so nothing reaches the FIFO.
  assign beat      = (state_q == StOwn) & owner_req & ~fifo_full & rst_n;
  assign burst_end = beat & (beat_cnt_q == CW'(BURST - 1));
  assign handover  = (state_q == StOwn) & (burst_end | ~owner_req);
  assign any_req   = |req;

  // On handover the current owner becomes the lowest-priority requester, so it
  // is re-granted only when it is the sole requester.
  assign arb_base  = (state_q == StOwn) ? owner_q : last_owner_q;

  // Round-robin scan starting one past arb_base, wrapping modulo N_REQ.
  always_comb begin
    win_idx   = arb_base;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = OW'((32'(arb_base) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  assign win_onehot = N_REQ'(1) << win_idx;

  // Next-state: grant on arbitration, count beats, release on burst end or drop.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    beat_total_d = beat_total_q;

    if (beat) begin
      beat_total_d = beat_total_q + CNT_W'(1);
    end

    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d    = StOwn;
          gnt_d      = win_onehot;
          owner_d    = win_idx;
          beat_cnt_d = '0;
        end
      end
      StOwn: begin
        if (handover) begin
          last_owner_d = owner_q;
          if (win_found) begin
            gnt_d      = win_onehot;
            owner_d    = win_idx;
            beat_cnt_d = '0;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; producer 0 wins first.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= OW'(N_REQ - 1);
      beat_cnt_q   <= '0;
      beat_total_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      beat_total_q <= beat_total_d;
    end
  end

  // Write data always follows the owner's slice, even without a beat.
  always_comb begin
    fifo_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        fifo_wdata = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign fifo_wr_rq = beat;
  assign ack        = beat ? gnt_q : '0;
  assign gnt        = gnt_q;
  assign owner      = owner_q;
  assign beat_total = beat_total_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a transaction-level reference model.
module tb_fifo_wr_arbiter;

  localparam int WIDTH = 4;
  localparam int N_REQ = 4;
  localparam int BURST = 4;
  localparam int CNT_W = 16;
  localparam int OW    = 2;

  logic                   clk_in = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       ack;
  logic [N_REQ-1:0]       gnt;
  logic [OW-1:0]          owner;
  logic                   fifo_wr_rq;
  logic [WIDTH-1:0]       fifo_wdata;
  logic                   fifo_full;
  logic [CNT_W-1:0]       beat_total;

  always #5 clk_in = ~clk_in;

  fifo_wr_arbiter #(
    .WIDTH (WIDTH),
    .N_REQ (N_REQ),
    .BURST (BURST),
    .CNT_W (CNT_W)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .gnt        (gnt),
    .owner      (owner),
    .fifo_wr_rq (fifo_wr_rq),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .beat_total (beat_total)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the port, how many beats it has had, running total.
  logic             m_valid;
  logic [OW-1:0]    m_cur;
  logic [OW-1:0]    m_last;
  int               m_beats;
  logic [CNT_W-1:0] m_total;

  // Producers: current data word and number of words still to send.
  logic [WIDTH-1:0] word [N_REQ];
  int               rem  [N_REQ];
  int               sent [N_REQ];
  int               exp_sent [N_REQ];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // First requester found scanning from last+1 upward with wrap-around.
  function automatic logic rr_pick(input logic [N_REQ-1:0] r, input logic [OW-1:0] last,
                                   output logic [OW-1:0] win);
    int c;
    win = last;
    for (int k = 1; k <= N_REQ; k++) begin
      c = (int'(last) + k) % N_REQ;
      if (r[OW'(c)]) begin
        win = OW'(c);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_cur   = '0;
    m_last  = OW'(N_REQ - 1);
    m_beats = 0;
    m_total = '0;
  endtask

  task automatic run_cycle(input logic [N_REQ-1:0] mask, input int full_pct,
                           input int refill_pct, input logic rst_val);
    logic [N_REQ-1:0] exp_gnt;
    logic             exp_beat;
    logic             rel;
    logic             found;
    logic [OW-1:0]    w;
    @(negedge clk_in);
    for (int i = 0; i < N_REQ; i++) begin
      if (rem[i] == 0 && int'($urandom_range(99)) < refill_pct) rem[i] = 1 + int'($urandom_range(9));
      req[i] = mask[i] && (rem[i] > 0);
      req_data[i*WIDTH +: WIDTH] = word[i];
    end
    fifo_full = int'($urandom_range(99)) < full_pct;
    rst_n     = rst_val;
    #1;
    exp_gnt  = m_valid ? (N_REQ'(1) << m_cur) : '0;
    exp_beat = m_valid && req[m_cur] && !fifo_full && rst_n;
    check_eq("gnt", 32'(gnt), 32'(exp_gnt));
    check_eq("owner", 32'(owner), 32'(m_cur));
    check_eq("fifo_wr_rq", 32'(fifo_wr_rq), 32'(exp_beat));
    check_eq("ack", 32'(ack), 32'(exp_beat ? exp_gnt : '0));
    check_eq("beat_total", 32'(beat_total), 32'(m_total));
    check_eq("fifo_wdata", 32'(fifo_wdata), 32'(word[m_cur]));
    if (fifo_wr_rq) sent[owner]++;
    if (!rst_n) begin
      model_reset();
    end else if (!m_valid) begin
      found = rr_pick(req, m_last, w);
      if (found) begin
        m_valid = 1'b1;
        m_cur   = w;
        m_beats = 0;
      end
    end else begin
      rel = (exp_beat && (m_beats + 1 == BURST)) || !req[m_cur];
      if (exp_beat) begin
        m_beats++;
        m_total++;
        exp_sent[m_cur]++;
        word[m_cur] = WIDTH'($urandom);
        rem[m_cur]--;
      end
      if (rel) begin
        m_last = m_cur;
        found  = rr_pick(req, m_last, w);
        if (found) begin
          m_cur   = w;
          m_beats = 0;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  int rst_left;

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      word[i]     = WIDTH'($urandom);
      rem[i]      = 0;
      sent[i]     = 0;
      exp_sent[i] = 0;
    end
    repeat (3) @(posedge clk_in);
    model_reset();
    @(negedge clk_in);
    #1;
    check_eq("reset_gnt", 32'(gnt), 32'(0));
    check_eq("reset_owner", 32'(owner), 32'(0));
    check_eq("reset_beat_total", 32'(beat_total), 32'(0));
    check_eq("reset_wr_rq", 32'(fifo_wr_rq), 32'(0));
    check_eq("reset_ack", 32'(ack), 32'(0));

    // Single producer, never full: back-to-back bursts re-granted to producer 0.
    repeat (40) run_cycle(4'b0001, 0, 100, 1'b1);
    // Two producers alternating bursts.
    repeat (60) run_cycle(4'b0101, 0, 100, 1'b1);
    // All producers with back-pressure and early drops.
    repeat (200) run_cycle(4'b1111, 30, 40, 1'b1);
    // All producers always refilling: wrap priority 3 -> 0 -> 1 ...
    repeat (60) run_cycle(4'b1111, 0, 100, 1'b1);
    // Random mix with occasional two-cycle resets mid-burst.
    rst_left = 0;
    for (int c = 0; c < 300; c++) begin
      if (rst_left > 0) begin
        rst_left--;
        run_cycle(4'($urandom), 20, 50, 1'b0);
      end else if ($urandom_range(99) < 3) begin
        rst_left = 1;
        run_cycle(4'($urandom), 20, 50, 1'b0);
      end else begin
        run_cycle(4'($urandom) | 4'b0001, 20, 50, 1'b1);
      end
    end
    // Reset, then all requesting: producer 0 must win first.
    run_cycle(4'b1111, 0, 100, 1'b0);
    run_cycle(4'b1111, 0, 100, 1'b0);
    repeat (40) run_cycle(4'b1111, 10, 100, 1'b1);

    for (int i = 0; i < N_REQ; i++) begin
      check_eq("beats_per_producer", 32'(sent[i]), 32'(exp_sent[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
